host_to_breakout_tx: RTL and testbench



---
 rtl/host_to_breakout_tx.sv | 174 +++++++++++++++++
 tb/tb_host_to_breakout_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_to_breakout_tx.sv
// host_to_breakout_tx: serializes the 8-bit digital output word and a rotating
// 48-bit slow control word onto the host-to-breakout LVDS data line.
// Frame = {SYNC[1:0], slot[1:0], port[7:0], slow chunk[11:0]}, sent MSB first with no gap between frames.
// Optional macro H2B_PARITY_EN appends an odd-parity bit, giving 25-bit frames.
// Ports:
//   i_clk            60 MHz link clock (also forwarded to the breakout)
//   i_reset          asynchronous active-high reset
//   i_en             link enable, sampled only at frame boundaries
//   i_port           digital output word, sampled at every frame load
//   i_acq_running, i_acq_reset_done, i_ledlevel, i_ledmode, i_port_status,
//   i_aio_dir, i_harp_conf, i_gpio_dir
//                    slow control fields, snapshotted when slot 0 is loaded
//   o_d0_s           serial data (registered)
//   o_frame_start    pulse on the first header bit of each frame
//   o_slow_done      pulse on the last bit of slot 3
module host_to_breakout_tx #(
  parameter logic [1:0] SYNC  = 2'b10,
  parameter int         SLOTS = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic [7:0]  i_port,
  input  logic        i_acq_running,
  input  logic        i_acq_reset_done,
  input  logic [3:0]  i_ledlevel,
  input  logic [1:0]  i_ledmode,
  input  logic [7:0]  i_port_status,
  input  logic [11:0] i_aio_dir,
  input  logic [1:0]  i_harp_conf,
  input  logic [15:0] i_gpio_dir,
  output logic        o_d0_s,
  output logic        o_frame_start,
  output logic        o_slow_done
);

`ifdef H2B_PARITY_EN
  localparam int FW = 25;
`else
  localparam int FW = 24;
`endif
  localparam logic [4:0] LAST_BIT = 5'(FW - 1);

  // The slot field is two bits wide and the slow word is exactly 4 x 12 bits.
  generate
    if (SLOTS != 4) begin : g_bad_slots
      $error("host_to_breakout_tx: SLOTS must be 4");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [4:0]    r_cnt;        // index of the frame bit currently on o_d0_s
  logic [1:0]    r_slot;       // slot of the frame currently on o_d0_s
  logic [FW-1:0] r_shift;      // remaining frame bits, next bit at the MSB
  logic [47:0]   r_slow_snap;
  logic          r_d0_s;
  logic          r_frame_start;
  logic          r_slow_done;

  logic          w_load;
  logic [1:0]    w_slot_nxt;
  logic [47:0]   w_slow_live;
  logic [47:0]   w_slow_src;
  logic [11:0]   w_chunk;
  logic [23:0]   w_base;
  logic [FW-1:0] w_frame;

  assign w_slow_live = {2'b00, i_acq_running, i_acq_reset_done, i_ledlevel, i_ledmode,
                        i_port_status, i_aio_dir, i_harp_conf, i_gpio_dir};

  // Next-state / frame-load decision. Loads happen from IDLE, or on the last
  // bit of a frame so the next frame follows with no gap.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_slot_nxt  = r_slot;
    case (r_state)
      ST_IDLE: begin
        w_slot_nxt = 2'd0;
        if (i_en) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (r_cnt == 5'd0) begin
          if (i_en) begin
            w_load     = 1'b1;
            w_slot_nxt = r_slot + 2'd1;
          end else begin
            w_slot_nxt  = 2'd0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Slot 0 takes the live inputs (the snapshot is captured on the same edge);
  // later slots read the snapshot so a superframe is self-consistent.
  assign w_slow_src = (w_slot_nxt == 2'd0) ? w_slow_live : r_slow_snap;

  always_comb begin
    w_chunk = w_slow_src[47:36];
    case (w_slot_nxt)
      2'd0:    w_chunk = w_slow_src[47:36];
      2'd1:    w_chunk = w_slow_src[35:24];
      2'd2:    w_chunk = w_slow_src[23:12];
      default: w_chunk = w_slow_src[11:0];
    endcase
  end

  assign w_base = {SYNC, w_slot_nxt, i_port, w_chunk};

`ifdef H2B_PARITY_EN
  // Odd parity: the appended bit makes the total count of ones odd.
  assign w_frame = {w_base, ~^w_base};
`else
  assign w_frame = w_base;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt         <= 5'd0;
      r_slot        <= 2'd0;
      r_shift       <= '0;
      r_slow_snap   <= '0;
      r_d0_s        <= 1'b0;
      r_frame_start <= 1'b0;
      r_slow_done   <= 1'b0;
    end else begin
      r_frame_start <= w_load;
      // The bit about to go out is the last one of slot 3.
      r_slow_done   <= (r_state == ST_SEND) && (r_cnt == 5'd1) && (r_slot == 2'd3);
      if (w_load) begin
        // Header MSB goes straight to the output flop; the rest queue up.
        r_d0_s  <= w_frame[FW-1];
        r_shift <= {w_frame[FW-2:0], 1'b0};
        r_cnt   <= LAST_BIT;
        r_slot  <= w_slot_nxt;
        if (w_slot_nxt == 2'd0) begin
          r_slow_snap <= w_slow_live;
        end
      end else if ((r_state == ST_SEND) && (r_cnt != 5'd0)) begin
        r_d0_s  <= r_shift[FW-1];
        r_shift <= {r_shift[FW-2:0], 1'b0};
        r_cnt   <= r_cnt - 5'd1;
      end else begin
        r_d0_s <= 1'b0;
        r_slot <= w_slot_nxt;
      end
    end
  end

  assign o_d0_s        = r_d0_s;
  assign o_frame_start = r_frame_start;
  assign o_slow_done   = r_slow_done;

endmodule

// File: tb/tb_host_to_breakout_tx.sv
// Self-checking bench for host_to_breakout_tx: a frame-level model predicts the
// serial line and pulses every cycle, plus literal checks on captured frames.
module tb_host_to_breakout_tx;

`ifdef H2B_PARITY_EN
  localparam int FW = 25;
`else
  localparam int FW = 24;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  port;
  logic        acq_running;
  logic        acq_reset_done;
  logic [3:0]  ledlevel;
  logic [1:0]  ledmode;
  logic [7:0]  port_status;
  logic [11:0] aio_dir;
  logic [1:0]  harp_conf;
  logic [15:0] gpio_dir;
  logic        d0_s;
  logic        frame_start;
  logic        slow_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  host_to_breakout_tx dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_en             (en),
    .i_port           (port),
    .i_acq_running    (acq_running),
    .i_acq_reset_done (acq_reset_done),
    .i_ledlevel       (ledlevel),
    .i_ledmode        (ledmode),
    .i_port_status    (port_status),
    .i_aio_dir        (aio_dir),
    .i_harp_conf      (harp_conf),
    .i_gpio_dir       (gpio_dir),
    .o_d0_s           (d0_s),
    .o_frame_start    (frame_start),
    .o_slow_done      (slow_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [47:0] slow_word();
    return {2'b00, acq_running, acq_reset_done, ledlevel, ledmode,
            port_status, aio_dir, harp_conf, gpio_dir};
  endfunction

  function automatic logic [FW-1:0] build(input logic [1:0] slot, input logic [7:0] p,
                                          input logic [47:0] slow);
    logic [47:0] sh;
    logic [23:0] b;
    sh = slow >> (12 * (3 - int'(slot)));
    b  = {2'b10, slot, p, sh[11:0]};
`ifdef H2B_PARITY_EN
    return {b, ~^b};
`else
    return b;
`endif
  endfunction

  logic          m_on = 1'b0;
  int            m_pos = 0;
  logic [1:0]    m_slot = 2'd0;
  logic [47:0]   m_snap = '0;
  logic [FW-1:0] m_frame = '0;
  logic          e_d0 = 1'b0;
  logic          e_fs = 1'b0;
  logic          e_sd = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_on = 1'b0; m_pos = 0; m_slot = 2'd0; m_snap = '0;
      e_d0 = 1'b0; e_fs = 1'b0; e_sd = 1'b0;
    end else begin
      e_fs = 1'b0;
      if (m_on && m_pos > 0) begin
        m_pos = m_pos - 1;
      end else if (en) begin
        m_slot = m_on ? 2'((int'(m_slot) + 1) % 4) : 2'd0;
        if (m_slot == 2'd0) m_snap = slow_word();
        m_frame = build(m_slot, port, m_snap);
        m_pos   = FW - 1;
        m_on    = 1'b1;
        e_fs    = 1'b1;
      end else begin
        m_on = 1'b0;
      end
      e_d0 = m_on ? m_frame[m_pos] : 1'b0;
      e_sd = m_on && (m_slot == 2'd3) && (m_pos == 0);
    end
  end

  // Per-cycle compare, on the inactive edge.
  always @(negedge clk) begin
    check("d0_s",        32'(d0_s),        32'(e_d0));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("slow_done",   32'(slow_done),   32'(e_sd));
  end

  // ---------------- capture helpers ----------------
  logic [FW-1:0] cf;
  logic          csd;
  int            cstart;

  task automatic capture(output logic [FW-1:0] f, output logic sd_last, output int start_cyc);
    int n;
    n = 0; f = '0; sd_last = 1'b0; start_cyc = cyc;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("frame_start_timeout", 32'(0), 32'(1));
      return;
    end
    start_cyc = cyc;
    for (int i = FW - 1; i >= 0; i--) begin
      if (i != FW - 1) @(negedge clk);
      f[i] = d0_s;
      if (i == 0) sd_last = slow_done;
    end
  endtask

  function automatic logic [23:0] base_of(input logic [FW-1:0] f);
    return 24'(f >> (FW - 24));
  endfunction

  task automatic chk_frame(input string name, input logic [FW-1:0] f, input logic [1:0] slot,
                           input logic [7:0] p, input logic [11:0] chunk);
    logic [23:0] b;
    b = base_of(f);
    check({name, ".sync"},  32'(b[23:22]), 32'(2'b10));
    check({name, ".slot"},  32'(b[21:20]), 32'(slot));
    check({name, ".port"},  32'(b[19:12]), 32'(p));
    check({name, ".chunk"}, 32'(b[11:0]),  32'(chunk));
  endtask

  logic [11:0] exp_chunk [4];
  int          prev_start;
  int          ones;
  int          pulses;

  initial begin
    rst = 1'b1; en = 1'b0; port = 8'h00;
    acq_running = 1'b0; acq_reset_done = 1'b0; ledlevel = 4'h0; ledmode = 2'b00;
    port_status = 8'h00; aio_dir = 12'h000; harp_conf = 2'b00; gpio_dir = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset.d0_s", 32'(d0_s), 32'(0));
    check("reset.frame_start", 32'(frame_start), 32'(0));
    check("reset.slow_done", 32'(slow_done), 32'(0));

    // First frame: port A5, slow word zero.
    rst = 1'b0; en = 1'b1; port = 8'hA5;
    capture(cf, csd, cstart);
`ifdef H2B_PARITY_EN
    check("first_frame", 32'(cf), 32'({24'h8A5000, 1'b0}));
`else
    check("first_frame", 32'(cf), 32'h008A5000);
`endif
    prev_start = cstart;

    // New slow inputs arrive mid-superframe: not visible until next slot 0.
    acq_running = 1'b1; ledlevel = 4'hF; gpio_dir = 16'hBEEF; port = 8'h00;
    capture(cf, csd, cstart);
    check("frame_period", 32'(cstart - prev_start), 32'(FW));
    chk_frame("sf0_slot1", cf, 2'd1, 8'h00, 12'h000);
    capture(cf, csd, cstart);
    chk_frame("sf0_slot2", cf, 2'd2, 8'h00, 12'h000);
    capture(cf, csd, cstart);
    chk_frame("sf0_slot3", cf, 2'd3, 8'h00, 12'h000);
    check("sf0_slow_done_last", 32'(csd), 32'(1));

    // Full superframe with the snapshot of the new inputs.
    exp_chunk[0] = 12'h2F0; exp_chunk[1] = 12'h000;
    exp_chunk[2] = 12'h00B; exp_chunk[3] = 12'hEEF;
    for (int s = 0; s < 4; s++) begin
      capture(cf, csd, cstart);
      chk_frame("sf1", cf, 2'(s), 8'h00, exp_chunk[s]);
      check("sf1_slow_done_last", 32'(csd), 32'(s == 3));
    end

    // gpio changes during slot 1, port changes during slot 2.
    capture(cf, csd, cstart);
    chk_frame("sf2_slot0", cf, 2'd0, 8'h00, 12'h2F0);
    fork
      capture(cf, csd, cstart);
      begin repeat (6) @(negedge clk); gpio_dir = 16'h1234; end
    join
    chk_frame("sf2_slot1", cf, 2'd1, 8'h00, 12'h000);
    fork
      capture(cf, csd, cstart);
      begin repeat (6) @(negedge clk); port = 8'hFF; end
    join
    chk_frame("sf2_slot2", cf, 2'd2, 8'h00, 12'h00B);
    capture(cf, csd, cstart);
    chk_frame("sf2_slot3", cf, 2'd3, 8'hFF, 12'hEEF);
    exp_chunk[2] = 12'h001; exp_chunk[3] = 12'h234;
    for (int s = 0; s < 4; s++) begin
      capture(cf, csd, cstart);
      chk_frame("sf3", cf, 2'(s), 8'hFF, exp_chunk[s]);
    end

    // Drop enable mid slot 1: slot 1 completes, then the line stays low.
    capture(cf, csd, cstart);
    chk_frame("sf4_slot0", cf, 2'd0, 8'hFF, 12'h2F0);
    fork
      capture(cf, csd, cstart);
      begin repeat (6) @(negedge clk); en = 1'b0; end
    join
    chk_frame("sf4_slot1", cf, 2'd1, 8'hFF, 12'h000);
    ones = 0; pulses = 0;
    repeat (30) begin
      @(negedge clk);
      ones += int'(d0_s);
      pulses += int'(frame_start);
    end
    check("idle_line_ones", 32'(ones), 32'(0));
    check("idle_frame_starts", 32'(pulses), 32'(0));
    en = 1'b1;
    capture(cf, csd, cstart);
    chk_frame("restart", cf, 2'd0, 8'hFF, 12'h2F0);

    // Reset in the middle of a frame.
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst.d0_s", 32'(d0_s), 32'(0));
    check("midrst.frame_start", 32'(frame_start), 32'(0));
    check("midrst.slow_done", 32'(slow_done), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    capture(cf, csd, cstart);
    chk_frame("after_rst", cf, 2'd0, 8'hFF, 12'h2F0);

    // Single port bit with zero slow word (exercises the parity bit).
    en = 1'b0;
    repeat (30) @(negedge clk);
    acq_running = 1'b0; ledlevel = 4'h0; gpio_dir = 16'h0000; port = 8'h01; en = 1'b1;
    capture(cf, csd, cstart);
`ifdef H2B_PARITY_EN
    check("port01_frame", 32'(cf), 32'({24'h801000, 1'b1}));
`else
    check("port01_frame", 32'(cf), 32'h00801000);
`endif
    prev_start = cstart;
    capture(cf, csd, cstart);
    check("port01_period", 32'(cstart - prev_start), 32'(FW));
    chk_frame("port01_slot1", cf, 2'd1, 8'h01, 12'h000);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
